conv_processor_core: RTL and testbench

- Top of the convolution engine: a control FSM, a 64x8 input-feature-map RAM, and a 3x3 convolution datapath.
- An external loader fills the RAM while the FSM is in LOAD.
- The datapath then convolves the 8x8 image with a fixed 3x3 kernel (valid padding) and streams 36 results out with addresses.
- The FSM reports completion on fsm_done.

---
 rtl/conv_pkg.sv | 17 +
 rtl/ifmd_ram.sv | 25 ++
 rtl/conv_processor_core.sv | 129 ++++++++++++
 tb/tb_conv_processor_core.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared sizes, default kernel, FSM states and tap addressing for the conv engine.
package conv_pkg;
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 6;
    localparam int IMG_W   = 8;
    localparam int K       = 3;
    localparam int OUT_DIM = IMG_W - K + 1;
    localparam int ACC_W   = 20;
    localparam logic [K*K*DATA_W-1:0] KERNEL_DEF = {K*K{8'h01}};

    typedef enum logic [1:0] {IDLE, LOAD, CONV, DONE} state_e;

    // Offset of kernel tap t (row-major) from the window's top-left pixel.
    function automatic logic [ADDR_W-1:0] tap_off(input logic [3:0] t);
        return ADDR_W'(t / 4'd3) * ADDR_W'(IMG_W) + ADDR_W'(t % 4'd3);
    endfunction
endpackage

// File: rtl/ifmd_ram.sv
// ifmd_ram: 64x8 input feature map RAM, synchronous read (old data on collision), debug taps.
module ifmd_ram
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [DATA_W-1:0] dbg0_o,
    output logic [DATA_W-1:0] dbg1_o,
    output logic [DATA_W-1:0] dbg2_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end

    assign dbg0_o = mem_q[0];
    assign dbg1_o = mem_q[1];
    assign dbg2_o = mem_q[2];
endmodule

// File: rtl/conv_processor_core.sv
// conv_processor_core: load/convolve control FSM plus a 3x3 valid-padding convolution over an 8x8 image.
module conv_processor_core
    import conv_pkg::*;
#(
    parameter logic [K*K*DATA_W-1:0] KERNEL = KERNEL_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_fsm,
    input  logic              write_done,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] IFMD_in,
    output logic              write_en,
    output logic              IFMD_write,
    output logic              conv_start,
    output logic              conv_done,
    output logic              fsm_done,
    output logic              OFMD_valid,
    output logic [ADDR_W-1:0] OFMD_addr,
    output logic [ACC_W-1:0]  OFMD_data,
    output logic [DATA_W-1:0] debug_mem0,
    output logic [DATA_W-1:0] debug_mem1,
    output logic [DATA_W-1:0] debug_mem2
);
    localparam logic [ADDR_W-1:0] LAST_N = ADDR_W'(OUT_DIM * OUT_DIM - 1);
    localparam logic [2:0]        LAST_C = 3'(OUT_DIM - 1);

    state_e state_q, state_d;
    logic   conv_start_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = start_fsm ? LOAD : IDLE;
            LOAD: state_d = write_done ? CONV : LOAD;
            CONV: state_d = conv_done ? DONE : CONV;
            DONE: state_d = start_fsm ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            conv_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            conv_start_q <= state_q == LOAD && state_d == CONV;
        end
    end

    assign write_en   = state_q == LOAD;
    assign IFMD_write = write_en;
    assign fsm_done   = state_q == DONE;
    assign conv_start = conv_start_q;

    // Each output takes 10 phases: phases 0..8 issue tap reads, phases 1..9 accumulate the returning pixels.
    logic                     run_q, ofmd_valid_q, conv_done_q;
    logic [3:0]               ph_q, tw;
    logic [2:0]               r_q, c_q;
    logic [ADDR_W-1:0]        n_q, ofmd_addr_q, raddr;
    logic signed [ACC_W-1:0]  acc_q, ofmd_data_q, prod, sum;
    logic [DATA_W-1:0]        rd_data;
    logic signed [DATA_W-1:0] w;
    logic [K*K*DATA_W+63:0]   kpad;

    assign raddr = {r_q, 3'b000} + ADDR_W'(c_q) + tap_off(ph_q);
    assign tw    = ph_q - 4'd1;
    assign kpad  = {64'b0, KERNEL};
    assign w     = kpad[{tw, 3'b000} +: DATA_W];
    assign prod  = ACC_W'($signed({1'b0, rd_data})) * ACC_W'(w);
    assign sum   = acc_q + prod;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            ph_q         <= '0;
            r_q          <= '0;
            c_q          <= '0;
            n_q          <= '0;
            acc_q        <= '0;
            ofmd_valid_q <= 1'b0;
            ofmd_addr_q  <= '0;
            ofmd_data_q  <= '0;
            conv_done_q  <= 1'b0;
        end else begin
            ofmd_valid_q <= 1'b0;
            conv_done_q  <= ofmd_valid_q && ofmd_addr_q == LAST_N;
            if (!run_q) begin
                run_q <= conv_start_q;
                ph_q  <= '0;
                r_q   <= '0;
                c_q   <= '0;
                n_q   <= '0;
                acc_q <= '0;
            end else if (ph_q == 4'd9) begin
                ph_q         <= '0;
                acc_q        <= '0;
                ofmd_valid_q <= 1'b1;
                ofmd_addr_q  <= n_q;
                ofmd_data_q  <= sum;
                n_q          <= n_q + 1'b1;
                c_q          <= c_q == LAST_C ? 3'd0 : c_q + 3'd1;
                r_q          <= c_q == LAST_C ? r_q + 3'd1 : r_q;
                run_q        <= n_q != LAST_N;
            end else begin
                ph_q  <= ph_q + 4'd1;
                acc_q <= ph_q == 4'd0 ? acc_q : sum;
            end
        end
    end

    assign OFMD_valid = ofmd_valid_q;
    assign OFMD_addr  = ofmd_addr_q;
    assign OFMD_data  = ofmd_data_q;
    assign conv_done  = conv_done_q;

    ifmd_ram u_ram (
        .clk     (clk),
        .we_i    (IFMD_write),
        .waddr_i (write_addr),
        .wdata_i (IFMD_in),
        .raddr_i (raddr),
        .rdata_o (rd_data),
        .dbg0_o  (debug_mem0),
        .dbg1_o  (debug_mem1),
        .dbg2_o  (debug_mem2)
    );
endmodule

// File: tb/tb_conv_processor_core.sv
// tb_conv_processor_core: three cores (all +1, centre-only, all -128 kernels) share stimulus; a scoreboard checks every result.
module tb_conv_processor_core;
    logic       clk = 1'b0, rst_n = 1'b0, start_fsm = 1'b0, write_done = 1'b0;
    logic [5:0] write_addr = '0;
    logic [7:0] IFMD_in = '0;
    logic       we[3], iw[3], cs[3], cd[3], fd[3], ov[3];
    logic [5:0] oa[3];
    logic [19:0] od[3];
    logic [7:0] m0[3], m1[3], m2[3];

    typedef struct {int dut; int cyc; int addr; longint data;} exp_t;
    exp_t sb[$];
    exp_t e;
    int   passed = 0, total = 0, cyc = 0;
    int   cscnt[3], cdcnt[3], vcnt[3], cd_cyc[3], fd_cyc[3];
    bit   fdp[3];

    always #5 clk = ~clk;

    conv_processor_core u_a (.clk(clk), .rst_n(rst_n), .start_fsm(start_fsm), .write_done(write_done),
        .write_addr(write_addr), .IFMD_in(IFMD_in), .write_en(we[0]), .IFMD_write(iw[0]), .conv_start(cs[0]),
        .conv_done(cd[0]), .fsm_done(fd[0]), .OFMD_valid(ov[0]), .OFMD_addr(oa[0]), .OFMD_data(od[0]),
        .debug_mem0(m0[0]), .debug_mem1(m1[0]), .debug_mem2(m2[0]));
    conv_processor_core #(.KERNEL({32'h0, 8'h01, 32'h0})) u_b (.clk(clk), .rst_n(rst_n), .start_fsm(start_fsm),
        .write_done(write_done), .write_addr(write_addr), .IFMD_in(IFMD_in), .write_en(we[1]), .IFMD_write(iw[1]),
        .conv_start(cs[1]), .conv_done(cd[1]), .fsm_done(fd[1]), .OFMD_valid(ov[1]), .OFMD_addr(oa[1]),
        .OFMD_data(od[1]), .debug_mem0(m0[1]), .debug_mem1(m1[1]), .debug_mem2(m2[1]));
    conv_processor_core #(.KERNEL({9{8'h80}})) u_c (.clk(clk), .rst_n(rst_n), .start_fsm(start_fsm),
        .write_done(write_done), .write_addr(write_addr), .IFMD_in(IFMD_in), .write_en(we[2]), .IFMD_write(iw[2]),
        .conv_start(cs[2]), .conv_done(cd[2]), .fsm_done(fd[2]), .OFMD_valid(ov[2]), .OFMD_addr(oa[2]),
        .OFMD_data(od[2]), .debug_mem0(m0[2]), .debug_mem1(m1[2]), .debug_mem2(m2[2]));

    task automatic chk(input bit ok, input string nm, input longint act, input longint req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    endtask

    // Ramp image pixel(r,c)=8r+c or flat 255 image; expected result per kernel.
    function automatic longint expv(int k, bit ramp, int r, int c);
        longint s = ramp ? 81 + 72 * r + 9 * c : 2295;
        longint p = ramp ? (r + 1) * 8 + c + 1 : 255;
        return k == 0 ? s : k == 1 ? p : -128 * s;
    endfunction

    task automatic push_job(input bit ramp, input int nmax);
        for (int n = 0; n < nmax; n++)
            for (int k = 0; k < 3; k++)
                sb.push_back('{k, 10 * n + 11, n, expv(k, ramp, n / 6, n % 6)});
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 3; k++) begin
            cscnt[k] = 0; cdcnt[k] = 0; vcnt[k] = 0; cd_cyc[k] = -1; fd_cyc[k] = -1;
        end
    endtask

    task automatic load(input bit ramp);
        int i = 0;
        while (!we[0] && i < 20) begin @(negedge clk); i++; end
        chk(we[0] == 1'b1, "load_entry", longint'(we[0]), 1);
        for (int a = 0; a < 64; a++) begin
            write_addr = 6'(a);
            IFMD_in    = ramp ? 8'(a) : 8'hFF;
            write_done = a == 63;
            @(negedge clk);
        end
        write_done = 1'b0;
    endtask

    task automatic wait_done();
        int i = 0;
        while (!(fd[0] && fd[1] && fd[2]) && i < 600) begin @(negedge clk); i++; end
        chk(i < 600, "done_timeout", i, 600);
        #1;
    endtask

    task automatic after_job(input bit ramp);
        logic [23:0] dm, dm_exp;
        dm_exp = ramp ? 24'h000102 : 24'hFFFFFF;
        for (int k = 0; k < 3; k++) begin
            dm = {m0[k], m1[k], m2[k]};
            chk(cscnt[k] == 1, "conv_start_count", cscnt[k], 1);
            chk(vcnt[k] == 36, "strobe_count", vcnt[k], 36);
            chk(cdcnt[k] == 1, "conv_done_count", cdcnt[k], 1);
            chk(cd_cyc[k] == 362, "conv_done_cycle", cd_cyc[k], 362);
            chk(fd_cyc[k] == 363, "fsm_done_cycle", fd_cyc[k], 363);
            chk(dm == dm_exp, "debug_mem", dm, dm_exp);
        end
        chk(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        cyc = cs[0] ? 0 : cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (cs[k]) cscnt[k]++;
            if (cd[k]) begin cdcnt[k]++; cd_cyc[k] = cyc; end
            if (fd[k] && !fdp[k]) fd_cyc[k] = cyc;
            fdp[k] = fd[k];
            if (ov[k]) begin
                vcnt[k]++;
                if (sb.size() == 0) chk(1'b0, "unexpected_strobe", k, -1);
                else begin
                    e = sb.pop_front();
                    chk(e.dut == k && e.addr == int'(oa[k]), "ofmd_addr", oa[k], e.addr);
                    chk(longint'($signed(od[k])) == e.data, "ofmd_data", longint'($signed(od[k])), e.data);
                    chk(cyc == e.cyc, "ofmd_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_stats();
        rst_n = 1'b0;
        start_fsm = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk({we[k], iw[k], cs[k], cd[k], fd[k], ov[k], oa[k], od[k]} == '0, "reset_outputs",
                {we[k], iw[k], cs[k], cd[k], fd[k], ov[k], oa[k], od[k]}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk(we[k] && iw[k], "write_en_after_reset", we[k], 1);
        // Job 1: ramp image.
        clear_stats(); push_job(1'b1, 36); load(1'b1); wait_done(); after_job(1'b1);
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) chk(fd[k] == 1'b1, "fsm_done_hold", fd[k], 1);
        start_fsm = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk(!fd[k] && !we[k], "idle_after_drop", {fd[k], we[k]}, 0);
        // Job 2: flat 255 image.
        start_fsm = 1'b1;
        clear_stats(); push_job(1'b0, 36); load(1'b0); wait_done(); after_job(1'b0);
        start_fsm = 1'b0;
        @(negedge clk);
        start_fsm = 1'b1;
        // Job 3: aborted by reset at cycle 100, so only results n=0..8 may appear.
        clear_stats(); push_job(1'b1, 9); load(1'b1);
        chk(cs[0] == 1'b1, "conv_start_after_load", cs[0], 1);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        start_fsm = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk(cdcnt[k] == 0, "abort_no_conv_done", cdcnt[k], 0);
            chk(vcnt[k] == 9, "abort_strobe_count", vcnt[k], 9);
            chk(!fd[k] && !we[k], "abort_idle", {fd[k], we[k]}, 0);
        end
        chk(sb.size() == 0, "abort_scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
